pe_dot_ctrl: RTL and testbench
==============================

// Module: pe_dot_ctrl
// PURPOSE
//  Sequencer for one my_pe processing element: runs a full fixed-point dot product.
//  Phase 1 loads vector B from an input stream into the PE local RAM.
//  Phase 2 streams vector A into the PE and accumulates sum(A[i]*B[i]) through the PE's cin input.
//  Sits between the vector source (DMA/global BRAM reader) and my_pe; one controller per PE.
// PARAMETERS
//  L_RAM_SIZE  6   PE RAM address width; must match the attached my_pe
//  LEN         64  vector length; legal range 1 <= LEN <= 2**L_RAM_SIZE
//  MAC_LAT     4   cycles from stable MAC inputs to valid pe_dout (xbip_multadd_0 latency)
// PORTS
//  aclk       in   1           clock
//  aresetn    in   1           synchronous, active-low reset
//  start      in   1           1-cycle pulse; begins an operation; sampled only in IDLE
//  busy       out  1           high in every state except IDLE
//  done       out  1           1-cycle pulse when result is updated
//  result     out  32          final accumulator, Q24.8 signed; held until next done
//  s_tdata    in   32          input word: LEN B words, then LEN A words
//  s_tvalid   in   1           s_tdata valid
//  s_tready   out  1           controller accepts s_tdata this cycle
//  pe_addr    out  L_RAM_SIZE  PE RAM address
//  pe_we      out  1           PE RAM write enable
//  pe_din     out  32          PE RAM write data
//  pe_ain     out  32          PE port A operand
//  pe_cin     out  32          PE addend (running accumulator)
//  pe_valid   out  1           PE valid
//  pe_dout    in   32          PE MAC result, Q24.8
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; idx, wait count, ain_reg, acc and result cleared.
//   Reset mid-operation aborts with no done pulse; the PE RAM contents are don't-care.
//  Word transfer: a word transfers when s_tvalid && s_tready. s_tready is high only in LOAD and CALC_A.
//   s_tdata is ignored in all other states.
//  IDLE:
//   - start=1 -> LOAD; idx=0; acc=0.
//   - start while busy is ignored.
//  LOAD:
//   - pe_we = transfer; pe_addr = idx; pe_din = s_tdata.
//   - Each transfer increments idx.
//   - Transfer at idx==LEN-1 -> CALC_RD with idx=0.
//   - s_tvalid gaps stall without writing.
//  CALC_RD (1 cycle):
//   - pe_we=0; pe_addr=idx, held for the rest of this element.
//   - The RAM read is 1-cycle latency, so bin is stable from the next cycle.
//   - -> CALC_A.
//  CALC_A:
//   - On transfer: ain_reg = s_tdata; wcnt = 0; -> CALC_WAIT.
//   - Otherwise stay.
//  CALC_WAIT:
//   - pe_ain=ain_reg, pe_cin=acc, pe_valid=1, all held constant.
//   - wcnt increments each cycle.
//   - When wcnt==MAC_LAT: acc = pe_dout.
//   - Then if idx==LEN-1 -> DONE, else idx++ and -> CALC_RD.
//  DONE (1 cycle):
//   - result = acc; done=1; -> IDLE the next cycle.
//   - busy drops in that IDLE cycle.
//  pe_dvalid from my_pe is unreliable and unused; completion is timed by wcnt only.
//  Outside CALC_WAIT: pe_valid=0, pe_ain=0, pe_cin=acc.
//  Arithmetic: all data are 32-bit two's complement Q24.8.
//   - Scaling and truncation are done inside the PE; the controller never rescales.
//   - Overflow wraps, matching the PE.
//  Latency with continuous s_tvalid:
//   - start to done = 1 + LEN + LEN*(MAC_LAT+3) cycles.
//   - Example: LEN=4, MAC_LAT=4 gives 33.
//  idx width = L_RAM_SIZE; LEN==2**L_RAM_SIZE is legal (idx terminates before wrap).
// STRUCTURE
//  Shared package pe_pkg:
//   - state encoding (IDLE, LOAD, CALC_RD, CALC_A, CALC_WAIT, DONE)
//   - DATA_W=32, FRAC_BITS=8, default MAC_LAT=4
//  Single flat module: one FSM, idx counter, wcnt counter, ain_reg/acc/result regs; no sub-module.
//  Integration wrapper pe_dot_top instantiates pe_dot_ctrl + my_pe.
// TESTING (pe_dot_top, LEN=4, MAC_LAT=4)
//  1. B=4x 0x100, A={0x100,0x200,0x300,0x400}, continuous valid
//     -> result=0x00000A00; done exactly 33 cycles after start.
//  2. B={0x200,0,0,0}, A={0xFFFFFF00,5,6,7} -> result=0xFFFFFE00 (-2.0).
//  3. Case 1 with s_tvalid low on every other cycle
//     -> same result; no PE write or MAC capture without a transfer.
//  4. start pulsed again while busy -> ignored; one done; result unchanged vs case 1.
//  5. aresetn low for 1 cycle in CALC_WAIT of element 2 -> IDLE, outputs 0, no done.
//     A fresh case 1 run then gives 0xA00.
//  6. B=4x 0x180, A=4x 0x180 (1.5*1.5*4) -> result=0x00000900; back-to-back runs need no reset.

Source files
------------

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared types and constants for the PE dot-product sequencer.
//                Holds the controller state encoding and the fixed-point
//                data format shared with my_pe (32-bit two's complement Q24.8).
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int DATA_W      = 32;  // data word width
    localparam int FRAC_BITS   = 8;   // Q24.8 fractional bits (scaling lives in the PE)
    localparam int MAC_LAT_DEF = 4;   // xbip_multadd_0 latency

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_CALC_RD   = 3'd2,
        ST_CALC_A    = 3'd3,
        ST_CALC_WAIT = 3'd4,
        ST_DONE      = 3'd5
    } pe_state_e;

endpackage
`default_nettype wire

// File: rtl/pe_dot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_stream_if / pe_bus_if
//  Description : Bus bundles for the PE dot-product sequencer.
//                pe_stream_if : valid/ready word stream from the vector source
//                               (tdata, tvalid driven by master; tready by slave).
//                pe_bus_if    : controller-to-PE bus (addr, we, din, ain, cin,
//                               valid driven by master; dout returned by the PE).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_stream_if;
    import pe_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

interface pe_bus_if #(
    parameter int ADDR_W = 6
);
    import pe_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] ain;
    logic [DATA_W-1:0] cin;
    logic              valid;
    logic [DATA_W-1:0] dout;

    modport master (output addr, output we, output din, output ain,
                    output cin, output valid, input dout);
    modport slave  (input  addr, input  we, input  din, input  ain,
                    input  cin, input  valid, output dout);
endinterface
`default_nettype wire

// File: rtl/pe_dot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pe_dot_ctrl
//  Description : Sequencer for one my_pe processing element computing a full
//                fixed-point dot product sum(A[i]*B[i]).
//                Phase 1 streams LEN B words into the PE RAM; phase 2 streams
//                LEN A words, each held on pe_ain for one MAC while the
//                running accumulator is fed back through pe_cin.
//  Ports       : aclk, aresetn  - clock, synchronous active-low reset
//                start          - 1-cycle pulse, sampled only in IDLE
//                busy           - high in every state except IDLE
//                done           - 1-cycle pulse, result valid in that cycle
//                result         - final accumulator (Q24.8), held until next done
//                s_axis         - input word stream (B words then A words)
//                pe             - bus to the attached my_pe
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_dot_ctrl
    import pe_pkg::*;
#(
    parameter int L_RAM_SIZE = 6,
    parameter int LEN        = 64,
    parameter int MAC_LAT    = MAC_LAT_DEF
) (
    input  wire logic              aclk,
    input  wire logic              aresetn,
    input  wire logic              start,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      result,
    pe_stream_if.slave             s_axis,
    pe_bus_if.master               pe
);

    localparam int WCNT_W = $clog2(MAC_LAT + 1);
    localparam logic [L_RAM_SIZE-1:0] LAST_IDX = L_RAM_SIZE'(LEN - 1);
    localparam logic [WCNT_W-1:0]     WCNT_END = WCNT_W'(MAC_LAT);

    pe_state_e               state_q, state_d;
    logic [L_RAM_SIZE-1:0]   idx_q, idx_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic [DATA_W-1:0]       ain_q, ain_d;
    logic [DATA_W-1:0]       acc_q, acc_d;
    logic [DATA_W-1:0]       result_q, result_d;

    logic xfer;
    logic idx_last;
    logic mac_ready;

    assign xfer      = s_axis.tvalid && s_axis.tready;
    assign idx_last  = (idx_q == LAST_IDX);
    // pe_dvalid is not trusted; the MAC output is taken purely by cycle count.
    assign mac_ready = (wcnt_q == WCNT_END);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start)               state_d = ST_LOAD;
            ST_LOAD:      if (xfer && idx_last)    state_d = ST_CALC_RD;
            ST_CALC_RD:                            state_d = ST_CALC_A;
            ST_CALC_A:    if (xfer)                state_d = ST_CALC_WAIT;
            ST_CALC_WAIT: if (mac_ready)           state_d = idx_last ? ST_DONE : ST_CALC_RD;
            ST_DONE:                               state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        result        = result_q;
        s_axis.tready = (state_q == ST_LOAD) || (state_q == ST_CALC_A);
        // Address is held at idx through CALC_RD/CALC_A/CALC_WAIT so the
        // registered RAM read keeps bin stable for the whole MAC.
        pe.addr       = idx_q;
        pe.we         = (state_q == ST_LOAD) && s_axis.tvalid;
        pe.din        = (state_q == ST_LOAD) ? s_axis.tdata : '0;
        pe.ain        = (state_q == ST_CALC_WAIT) ? ain_q : '0;
        pe.cin        = acc_q;
        pe.valid      = (state_q == ST_CALC_WAIT);
    end

    // ------------------------------------------------------------------
    // Datapath: index, wait counter, operand and accumulator registers
    // ------------------------------------------------------------------
    always_comb begin
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        ain_d    = ain_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d = '0;
                    acc_d = '0;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    idx_d = idx_last ? '0 : idx_q + L_RAM_SIZE'(1);
                end
            end
            ST_CALC_A: begin
                if (xfer) begin
                    ain_d  = s_axis.tdata;
                    wcnt_d = '0;
                end
            end
            ST_CALC_WAIT: begin
                if (mac_ready) begin
                    acc_d = pe.dout;
                    // Result is loaded on the final capture so it is already
                    // valid during the DONE cycle that carries the done pulse.
                    if (idx_last) begin
                        result_d = pe.dout;
                    end else begin
                        idx_d = idx_q + L_RAM_SIZE'(1);
                    end
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            idx_q    <= '0;
            wcnt_q   <= '0;
            ain_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            idx_q    <= idx_d;
            wcnt_q   <= wcnt_d;
            ain_q    <= ain_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_dot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_dot_ctrl
//  Description : Directed self-checking bench for pe_dot_ctrl (LEN=4,
//                MAC_LAT=4) with a behavioural my_pe model: 64-word RAM with
//                registered read, Q24.8 multiply-add through a 4-stage pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_dot_ctrl;
    import pe_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] result;

    pe_stream_if             s_if ();
    pe_bus_if #(.ADDR_W(6))  pe_if ();

    pe_dot_ctrl #(
        .L_RAM_SIZE (6),
        .LEN        (4),
        .MAC_LAT    (4)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .s_axis  (s_if.slave),
        .pe      (pe_if.master)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- behavioural my_pe ----------------
    logic [31:0] ram [0:63];
    logic [31:0] bin_q;
    logic [31:0] pipe [0:3];

    function automatic logic [31:0] mac(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        logic signed [63:0] p;
        p = $signed(a) * $signed(b);
        return p[39:8] + c;
    endfunction

    always @(posedge aclk) begin
        if (pe_if.we) ram[pe_if.addr] <= pe_if.din;
        bin_q   <= ram[pe_if.addr];
        pipe[0] <= mac(pe_if.ain, bin_q, pe_if.cin);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
        pipe[3] <= pipe[2];
    end
    assign pe_if.dout = pipe[3];

    // ---------------- activity monitors ----------------
    int  we_cnt, we_bad, mac_cnt, done_cnt;
    logic valid_prev;
    always @(posedge aclk) begin
        if (pe_if.we) we_cnt <= we_cnt + 1;
        if (pe_if.we && !(s_if.tvalid && s_if.tready)) we_bad <= we_bad + 1;
        if (pe_if.valid && !valid_prev) mac_cnt <= mac_cnt + 1;
        valid_prev <= pe_if.valid;
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_cmp, n_err;
    logic [31:0] bv [4];
    logic [31:0] av [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one operation: start pulse at k=0, then feeds bv/av on the stream.
    task automatic run_dot(input bit gappy, input bit restart, input bit abort,
                           output int done_k);
        int ptr;
        bit seen;
        ptr    = 0;
        seen   = 1'b0;
        done_k = -1;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge aclk);
            start       = (k == 0) || (restart && k == 10);
            s_if.tvalid = (ptr < 8) && (!gappy || k[0]);
            if (ptr < 4)      s_if.tdata = bv[ptr];
            else if (ptr < 8) s_if.tdata = av[ptr-4];
            else              s_if.tdata = 32'h0;
            #1;
            if (s_if.tvalid && s_if.tready) ptr++;
            if (abort && pe_if.valid && pe_if.addr == 6'd1) begin
                aresetn = 1'b0;
                seen    = 1'b1;
            end else if (!abort && done) begin
                done_k = k;
                seen   = 1'b1;
            end
        end
        start       = 1'b0;
        s_if.tvalid = 1'b0;
        check("op_reached_event", {31'b0, seen}, 32'd1);
        if (!abort) begin
            @(negedge aclk); #1;
            check("busy_after_done", {31'b0, busy}, 32'd0);
            check("done_one_cycle",  {31'b0, done}, 32'd0);
        end
    endtask

    task automatic load_case1();
        bv = '{32'h100, 32'h100, 32'h100, 32'h100};
        av = '{32'h100, 32'h200, 32'h300, 32'h400};
    endtask

    int dk, we0, mac0, dn0;

    initial begin
        n_cmp = 0; n_err = 0;
        we_cnt = 0; we_bad = 0; mac_cnt = 0; done_cnt = 0; valid_prev = 1'b0;
        for (int i = 0; i < 4; i++) pipe[i] = 32'h0;
        start = 1'b0;
        aresetn = 1'b0;
        s_if.tvalid = 1'b1;          // must be ignored while in reset / IDLE
        s_if.tdata  = 32'hDEAD_BEEF;
        repeat (3) @(negedge aclk);
        #1;
        check("rst_busy",   {31'b0, busy},         32'd0);
        check("rst_done",   {31'b0, done},         32'd0);
        check("rst_result", result,                32'd0);
        check("rst_tready", {31'b0, s_if.tready},  32'd0);
        check("rst_we",     {31'b0, pe_if.we},     32'd0);
        check("rst_valid",  {31'b0, pe_if.valid},  32'd0);
        check("rst_din",    pe_if.din,             32'd0);
        check("rst_ain",    pe_if.ain,             32'd0);
        check("rst_cin",    pe_if.cin,             32'd0);
        check("rst_addr",   {26'b0, pe_if.addr},   32'd0);
        aresetn = 1'b1;
        @(negedge aclk); #1;
        check("idle_tready_ignores_tvalid", {31'b0, s_if.tready}, 32'd0);
        check("idle_no_we",                 {31'b0, pe_if.we},    32'd0);
        s_if.tvalid = 1'b0;

        // Case 1: 1.0 * (1+2+3+4) = 10.0, latency 1+4+4*7 = 33
        load_case1();
        we0 = we_cnt; mac0 = mac_cnt; dn0 = done_cnt;
        run_dot(1'b0, 1'b0, 1'b0, dk);
        check("c1_result",  result,              32'h0000_0A00);
        check("c1_latency", dk,                  32'd33);
        check("c1_writes",  we_cnt - we0,        32'd4);
        check("c1_macs",    mac_cnt - mac0,      32'd4);
        check("c1_dones",   done_cnt - dn0,      32'd1);

        // Case 2: -1.0 * 2.0 = -2.0, remaining B words are zero
        bv = '{32'h200, 32'h0, 32'h0, 32'h0};
        av = '{32'hFFFF_FF00, 32'd5, 32'd6, 32'd7};
        run_dot(1'b0, 1'b0, 1'b0, dk);
        check("c2_result", result, 32'hFFFF_FE00);

        // Case 3: case 1 with tvalid only on odd cycles
        load_case1();
        we0 = we_cnt; mac0 = mac_cnt;
        run_dot(1'b1, 1'b0, 1'b0, dk);
        check("c3_result",      result,         32'h0000_0A00);
        check("c3_writes",      we_cnt - we0,   32'd4);
        check("c3_macs",        mac_cnt - mac0, 32'd4);
        check("c3_we_no_xfer",  we_bad,         32'd0);
        check("c3_latency_gt",  {31'b0, (dk > 33)}, 32'd1);

        // Case 4: second start while busy is ignored
        dn0 = done_cnt;
        run_dot(1'b0, 1'b1, 1'b0, dk);
        check("c4_result",  result,         32'h0000_0A00);
        check("c4_latency", dk,             32'd33);
        check("c4_dones",   done_cnt - dn0, 32'd1);
        check("c4_idle_after", {31'b0, busy}, 32'd0);

        // Case 5: reset in CALC_WAIT of element 2 aborts without done
        dn0 = done_cnt;
        run_dot(1'b0, 1'b0, 1'b1, dk);
        @(negedge aclk); #1;
        check("c5_busy",   {31'b0, busy},        32'd0);
        check("c5_done",   {31'b0, done},        32'd0);
        check("c5_result", result,               32'd0);
        check("c5_valid",  {31'b0, pe_if.valid}, 32'd0);
        check("c5_cin",    pe_if.cin,            32'd0);
        check("c5_tready", {31'b0, s_if.tready}, 32'd0);
        aresetn = 1'b1;
        repeat (40) @(negedge aclk);
        #1;
        check("c5_no_done", done_cnt - dn0, 32'd0);
        check("c5_stays_idle", {31'b0, busy}, 32'd0);
        load_case1();
        run_dot(1'b0, 1'b0, 1'b0, dk);
        check("c5_rerun_result", result, 32'h0000_0A00);

        // Case 6: 1.5*1.5*4 = 9.0, run back-to-back without reset
        bv = '{32'h180, 32'h180, 32'h180, 32'h180};
        av = '{32'h180, 32'h180, 32'h180, 32'h180};
        run_dot(1'b0, 1'b0, 1'b0, dk);
        check("c6_result",  result, 32'h0000_0900);
        check("c6_latency", dk,     32'd33);
        repeat (3) @(negedge aclk);
        #1;
        check("c6_result_held", result, 32'h0000_0900);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
